fcvt_float_int: RTL

Multi-cycle float-to-integer converter implementing the RISC-V FCVT.W.S / FCVT.WU.S semantics with all five rounding modes, saturation and exception flags. It is the float-to-int counterpart of the iterative int-to-float path. It sits beside the integer ALU in the execute stage and is launched by a one-cycle `start` pulse. It holds `busy` until a single-cycle `done` presents the result and flags.

---
 rtl/fcvt_float_int.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fcvt_float_int.sv
// ============================================================================
// Module      : fcvt_float_int
// Description : Iterative binary32 to 32-bit integer converter (FCVT.W.S / FCVT.WU.S)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcvt_float_int (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_nx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] C_RM_RNE = 3'b000;
  localparam logic [2:0] C_RM_RTZ = 3'b001;
  localparam logic [2:0] C_RM_RDN = 3'b010;
  localparam logic [2:0] C_RM_RUP = 3'b011;
  localparam logic [2:0] C_RM_RMM = 3'b100;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic [32:0] mag_q, mag_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic        left_q, left_d;
  logic [4:0]  nshift_q, nshift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        nan_q, nan_d;
  logic        sat_q, sat_d;
  logic [31:0] result_q, result_d;
  logic        nv_q, nv_d;
  logic        nx_q, nx_d;

  // Operand unpack and shift-count decode, used only when a start is accepted
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_ld_nan, w_ld_sat, w_ld_zero, w_ld_left, w_ld_st;
  logic [7:0]  w_ld_rsh;
  logic [4:0]  w_ld_n;
  logic [32:0] w_ld_mag;

  always_comb begin
    w_exp     = operand[30:23];
    w_man     = operand[22:0];
    w_ld_nan  = (w_exp == 8'hFF) && (w_man != 23'd0);
    // Infinity lands here too: E = 255 means e >= 32
    w_ld_sat  = (w_exp >= 8'd159) && !w_ld_nan;
    w_ld_zero = (w_exp == 8'd0);
    w_ld_left = (w_exp >= 8'd150);
    w_ld_st   = w_ld_zero && (w_man != 23'd0);
    w_ld_rsh  = 8'd150 - w_exp;
    w_ld_n    = 5'd0;
    w_ld_mag  = 33'd0;
    if (!(w_ld_nan || w_ld_sat || w_ld_zero)) begin
      w_ld_mag = {9'd0, 1'b1, w_man};
      if (w_ld_left) begin
        w_ld_n = w_exp[4:0] - 5'd22;
      end else if (w_ld_rsh > 8'd25) begin
        w_ld_n = 5'd25;
      end else begin
        w_ld_n = w_ld_rsh[4:0];
      end
    end
  end

  // Rounding and range check on the fully aligned magnitude
  logic        w_inc;
  logic [32:0] w_r;
  logic [31:0] w_neg;
  logic [31:0] w_sat_val;
  logic        w_ovf;
  logic [31:0] w_rnd_res;
  logic        w_rnd_nv;
  logic        w_rnd_nx;

  always_comb begin
    unique case (rm_q)
      C_RM_RNE: w_inc = g_q & (st_q | mag_q[0]);
      C_RM_RTZ: w_inc = 1'b0;
      C_RM_RDN: w_inc = sign_q & (g_q | st_q);
      C_RM_RUP: w_inc = ~sign_q & (g_q | st_q);
      C_RM_RMM: w_inc = g_q;
      default:  w_inc = 1'b0;
    endcase
    w_r   = mag_q + {32'd0, w_inc};
    w_neg = (~w_r[31:0]) + 32'd1;

    // Every overflow direction clips to the same per-sign/signedness limit
    if (uns_q) begin
      w_sat_val = sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
      w_ovf     = sign_q ? (w_r != 33'd0) : w_r[32];
    end else begin
      w_sat_val = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_ovf     = sign_q ? (w_r > 33'h0_8000_0000) : (w_r > 33'h0_7FFF_FFFF);
    end

    if (nan_q) begin
      w_rnd_res = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      w_rnd_nv  = 1'b1;
    end else if (sat_q || w_ovf) begin
      w_rnd_res = w_sat_val;
      w_rnd_nv  = 1'b1;
    end else begin
      w_rnd_res = (sign_q && !uns_q) ? w_neg : w_r[31:0];
      w_rnd_nv  = 1'b0;
    end
    w_rnd_nx = (g_q | st_q) & ~w_rnd_nv;
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    mag_d    = mag_q;
    g_d      = g_q;
    st_d     = st_q;
    left_d   = left_q;
    nshift_d = nshift_q;
    cnt_d    = cnt_q;
    nan_d    = nan_q;
    sat_d    = sat_q;
    result_d = result_q;
    nv_d     = nv_q;
    nx_d     = nx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d   = operand[31];
          uns_d    = is_unsigned;
          rm_d     = rm;
          mag_d    = w_ld_mag;
          g_d      = 1'b0;
          st_d     = w_ld_st;
          left_d   = w_ld_left;
          nshift_d = w_ld_n;
          cnt_d    = 5'd0;
          nan_d    = w_ld_nan;
          sat_d    = w_ld_sat;
          state_d  = (w_ld_n != 5'd0) ? S_SHIFT : S_ROUND;
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[31:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[32:1]};
          g_d   = mag_q[0];
          st_d  = st_q | g_q;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_d == nshift_q) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = w_rnd_res;
        nv_d     = w_rnd_nv;
        nx_d     = w_rnd_nx;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      uns_q    <= 1'b0;
      rm_q     <= 3'd0;
      mag_q    <= 33'd0;
      g_q      <= 1'b0;
      st_q     <= 1'b0;
      left_q   <= 1'b0;
      nshift_q <= 5'd0;
      cnt_q    <= 5'd0;
      nan_q    <= 1'b0;
      sat_q    <= 1'b0;
      result_q <= 32'd0;
      nv_q     <= 1'b0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      mag_q    <= mag_d;
      g_q      <= g_d;
      st_q     <= st_d;
      left_q   <= left_d;
      nshift_q <= nshift_d;
      cnt_q    <= cnt_d;
      nan_q    <= nan_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      nv_q     <= nv_d;
      nx_q     <= nx_d;
    end
  end

  assign busy    = (state_q == S_SHIFT) || (state_q == S_ROUND);
  assign done    = (state_q == S_DONE);
  assign result  = result_q;
  assign flag_nv = nv_q;
  assign flag_nx = nx_q;

endmodule

`default_nettype wire
